// File: rtl/mem_loader_if.sv
// Memory write port driven by the serial loader into the data memory.
// The loader is the master; the memory side consumes the strobe, address and word.
interface mem_loader_if #(
  parameter int ADDR_W = 12
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/mem_loader.sv
// UART (8N1) memory loader: assembles 4 bytes little-endian into a word and writes it once.
// Write strobe follows the 4th stop bit by one cycle; no backpressure, the memory must accept every write.
module mem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 12
) (
  input  logic              clk_in,
  input  logic              RST,
  input  logic              rx,
  input  logic              load_en,
  output logic              cpu_hold,
  mem_loader_if.master      wr,
  output logic [ADDR_W:0]   word_count,
  output logic              frame_err,
  output logic              overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic              rx_meta_q, rx_s_q, rx_prev_q, load_en_q;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q, asm_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              frame_err_q, frame_err_d;
  logic              overflow_q, overflow_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              byte_ok;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    word_count_d = word_count_q;
    frame_err_d  = frame_err_q;
    overflow_d   = overflow_q;
    byte_ok      = 1'b0;
    cpu_hold_d   = load_en | wr_en_q;

    // Address advances after the strobe; it parks on the last address once memory is full.
    if (wr_en_q) begin
      word_count_d = word_count_q + 1'b1;
      if (wr_addr_q != ADDR_MAX) wr_addr_d = wr_addr_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d   = S_START;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s_q) byte_ok = 1'b1;
          else        frame_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Partial bytes live in asm_q so wr_data only changes when a word is actually written.
    if (byte_ok) begin
      byte_idx_d = byte_idx_q + 1'b1;
      if (byte_idx_q == 2'd3) begin
        if (word_count_q[ADDR_W]) begin
          overflow_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_data_d = {shift_q, asm_q};
        end
      end else begin
        asm_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
      end
    end

    if (!load_en) begin
      state_d    = S_IDLE;
      byte_idx_d = '0;
      wr_en_d    = 1'b0;
    end else if (!load_en_q) begin
      wr_addr_d    = '0;
      word_count_d = '0;
      byte_idx_d   = '0;
      frame_err_d  = 1'b0;
      overflow_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      load_en_q    <= 1'b0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      word_count_q <= '0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      cpu_hold_q   <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      load_en_q    <= load_en;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      word_count_q <= word_count_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  assign cpu_hold   = cpu_hold_q;
  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = wr_addr_q;
  assign wr.wr_data = wr_data_q;
  assign word_count = word_count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader at CLKS_PER_BIT=4, ADDR_W=4.
// Table of words plus hand-written sequences for framing, glitch, overflow, session and reset cases.
module tb_mem_loader;

  localparam int CPB = 4;
  localparam int AW  = 4;

  logic        clk_in = 1'b0;
  logic        RST;
  logic        rx;
  logic        load_en;
  logic        cpu_hold;
  logic [AW:0] word_count;
  logic        frame_err;
  logic        overflow;

  mem_loader_if #(.ADDR_W(AW)) wr_if ();

  mem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk_in     (clk_in),
    .RST        (RST),
    .rx         (rx),
    .load_en    (load_en),
    .cpu_hold   (cpu_hold),
    .wr         (wr_if),
    .word_count (word_count),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];

  always @(negedge clk_in) begin
    if (wr_if.wr_en) begin
      log_addr.push_back(wr_if.wr_addr);
      log_data.push_back(wr_if.wr_data);
    end
  end

  typedef struct {
    logic [7:0]    b0, b1, b2, b3;
    logic [31:0]   data;
    logic [AW-1:0] addr;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(CPB);
    end
    rx = stop;
    cyc(CPB);
    rx = 1'b1;
    cyc(2 * CPB);
  endtask

  task automatic send_word(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
    cyc(6);
  endtask

  task automatic new_session();
    load_en = 1'b0;
    cyc(3);
    log_addr.delete();
    log_data.delete();
    load_en = 1'b1;
    cyc(3);
  endtask

  vec_t vecs[3];

  initial begin
    vecs[0] = '{b0: 8'h78, b1: 8'h56, b2: 8'h34, b3: 8'h12, data: 32'h12345678, addr: 4'd0};
    vecs[1] = '{b0: 8'hAA, b1: 8'h55, b2: 8'h00, b3: 8'hFF, data: 32'hFF0055AA, addr: 4'd1};
    vecs[2] = '{b0: 8'h01, b1: 8'h02, b2: 8'h03, b3: 8'h04, data: 32'h04030201, addr: 4'd2};

    RST = 1'b1; load_en = 1'b0; rx = 1'b1;
    @(posedge clk_in); #1;
    cyc(3);
    @(negedge clk_in);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_wr_en", wr_if.wr_en, 0);
    chk("rst_wr_addr", wr_if.wr_addr, 0);
    chk("rst_wr_data", wr_if.wr_data, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk_in); #1;
    RST = 1'b0;

    // Basic words, one per table row, in a single session.
    load_en = 1'b1;
    cyc(3);
    chk("session_cpu_hold", cpu_hold, 1);
    for (int i = 0; i < 3; i++) begin
      send_word(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
      chk($sformatf("vec%0d_writes", i), log_addr.size(), i + 1);
      chk($sformatf("vec%0d_addr", i), log_addr[i], vecs[i].addr);
      chk($sformatf("vec%0d_data", i), log_data[i], vecs[i].data);
      chk($sformatf("vec%0d_word_count", i), word_count, i + 1);
      chk($sformatf("vec%0d_wr_addr", i), wr_if.wr_addr, i + 1);
      chk($sformatf("vec%0d_wr_data_hold", i), wr_if.wr_data, vecs[i].data);
    end

    // Framing error in the middle of a word.
    new_session();
    chk("restart_word_count", word_count, 0);
    chk("restart_wr_addr", wr_if.wr_addr, 0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h99, 1'b0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    cyc(6);
    chk("ferr_flag", frame_err, 1);
    chk("ferr_writes", log_addr.size(), 1);
    chk("ferr_addr", log_addr[0], 0);
    chk("ferr_data", log_data[0], 32'h44332211);

    // One-cycle low glitch on the line.
    new_session();
    chk("glitch_ferr_cleared", frame_err, 0);
    rx = 1'b0;
    cyc(1);
    rx = 1'b1;
    cyc(20);
    chk("glitch_writes", log_addr.size(), 0);
    chk("glitch_frame_err", frame_err, 0);
    chk("glitch_overflow", overflow, 0);
    chk("glitch_word_count", word_count, 0);

    // Fill all 16 addresses, then one more word.
    for (int k = 0; k < 16; k++) send_word(8'(k), 8'hA5, 8'hA5, 8'hA5);
    chk("full_writes", log_addr.size(), 16);
    chk("full_overflow_clear", overflow, 0);
    chk("full_word_count", word_count, 16);
    begin
      int bad = 0;
      for (int k = 0; k < 16; k++) if (log_addr[k] !== 4'(k)) bad++;
      chk("full_addr_sequence", bad, 0);
    end
    chk("full_last_data", log_data[15], 32'hA5A5A50F);
    send_word(8'hEE, 8'hEE, 8'hEE, 8'hEE);
    chk("ovf_flag", overflow, 1);
    chk("ovf_no_write", log_addr.size(), 16);
    chk("ovf_word_count", word_count, 16);
    chk("ovf_wr_data_hold", wr_if.wr_data, 32'hA5A5A50F);

    // Flags and count hold for display after the session ends.
    load_en = 1'b0;
    cyc(4);
    chk("hold_word_count", word_count, 16);
    chk("hold_overflow", overflow, 1);

    // Session dropped after two bytes, then restarted.
    load_en = 1'b1;
    cyc(3);
    log_addr.delete();
    log_data.delete();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    load_en = 1'b0;
    @(negedge clk_in);
    chk("drop_cpu_hold_delay", cpu_hold, 1);
    @(negedge clk_in);
    chk("drop_cpu_hold_low", cpu_hold, 0);
    @(posedge clk_in); #1;
    load_en = 1'b1;
    @(negedge clk_in);
    chk("raise_cpu_hold_delay", cpu_hold, 0);
    @(negedge clk_in);
    chk("raise_cpu_hold_high", cpu_hold, 1);
    cyc(2);
    send_word(8'h01, 8'h02, 8'h03, 8'h04);
    chk("drop_writes", log_addr.size(), 1);
    chk("drop_addr", log_addr[0], 0);
    chk("drop_data", log_data[0], 32'h04030201);
    chk("drop_word_count", word_count, 1);

    // Reset in the middle of the data bits.
    rx = 1'b0;
    cyc(CPB);
    rx = 1'b1;
    cyc(2 * CPB);
    RST = 1'b1;
    cyc(1);
    @(negedge clk_in);
    chk("mid_rst_cpu_hold", cpu_hold, 0);
    chk("mid_rst_wr_en", wr_if.wr_en, 0);
    chk("mid_rst_wr_addr", wr_if.wr_addr, 0);
    chk("mid_rst_wr_data", wr_if.wr_data, 0);
    chk("mid_rst_word_count", word_count, 0);
    @(posedge clk_in); #1;
    RST = 1'b0;
    cyc(40);
    log_addr.delete();
    log_data.delete();
    send_word(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    chk("post_rst_writes", log_addr.size(), 1);
    chk("post_rst_addr", log_addr[0], 0);
    chk("post_rst_data", log_data[0], 32'hEFBEADDE);
    chk("post_rst_word_count", word_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clk_in cycles per serial bit (115200 baud at 100 MHz); legal range >= 4.
REQ-002 Parameter ADDR_W, default 12, width of the data-memory word address.
REQ-003 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 load_en  input  1  board switch; high = loading session active.
REQ-007 cpu_hold  output  1  high while loading; holds the CPU pipeline in reset.
REQ-008 wr_en  output  1  one-cycle memory write strobe.
REQ-009 wr_addr  output  ADDR_W  word address for the write.
REQ-010 wr_data  output  32  word to write.
REQ-011 word_count  output  ADDR_W+1  words written in the current session.
REQ-012 frame_err  output  1  sticky framing-error flag.
REQ-013 overflow  output  1  sticky flag: a write was attempted past the last address.

Function
REQ-014 rx is passed through a 2-flop synchronizer; all receiver logic uses only the synchronized value rx_s.
REQ-015 Receiver FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE->START when load_en=1 and rx_s falls from 1 to 0; the bit counter clears on entry to START.
REQ-017 START: sample rx_s after CLKS_PER_BIT/2 cycles (integer division); 0 -> DATA; 1 -> IDLE (false start, no flag).
REQ-018 DATA: sample 8 bits, each CLKS_PER_BIT cycles after the previous sample, LSB first, into a shift register; ->STOP after bit 7.
REQ-019 STOP: sample after CLKS_PER_BIT cycles; 1 -> byte accepted; 0 -> byte discarded and frame_err set; both cases -> IDLE.
REQ-020 Accepted bytes assemble little-endian: 1st byte -> wr_data[7:0], 4th byte -> wr_data[31:24]; byte index 0..3 wraps to 0.
REQ-021 The cycle after the 4th byte is accepted, wr_en=1 for exactly one cycle with the current wr_addr and the assembled wr_data.
REQ-022 The cycle after the wr_en pulse, wr_addr increments by 1 and word_count increments by 1.
REQ-023 A discarded (framing-error) byte does not advance the byte index; the partial word is kept.
REQ-024 When wr_addr = 2^ADDR_W-1 has been written, the next completed word sets overflow, does not pulse wr_en, and leaves wr_addr unchanged; word_count saturates at 2^ADDR_W.
REQ-025 cpu_hold = load_en registered (1-cycle delay); it deasserts no earlier than the cycle after any in-flight wr_en.
REQ-026 Rising edge of load_en starts a session: wr_addr, word_count, byte index, frame_err and overflow clear to 0.
REQ-027 load_en=0 mid-byte: the FSM aborts to IDLE immediately, the partial word is discarded, and no wr_en is issued; word_count and the flags hold their values for display.
REQ-028 wr_data holds its last value between writes; wr_addr and wr_data are stable during wr_en.

Reset
REQ-029 RST=1 on a clock edge: FSM->IDLE, all counters and the shift register clear, and every output goes to 0 (cpu_hold=0, wr_en=0, wr_addr=0, wr_data=0, word_count=0, frame_err=0, overflow=0); synchronizer flops reset to 1.
REQ-030 RST has priority over load_en and an in-progress reception; the first byte after reset release must begin with a new start bit.

Verification (CLKS_PER_BIT=4, ADDR_W=4)
REQ-031 load_en 0->1, send bytes 0x78,0x56,0x34,0x12 -> one wr_en pulse with wr_addr=0, wr_data=0x12345678; then word_count=1, wr_addr=1.
REQ-032 Send 0x11,0x22 then a byte with stop bit 0, then 0x33,0x44 -> frame_err=1; one write of 0x44332211 at addr 0.
REQ-033 Glitch: rx low for 1 bit-time/4 with load_en=1 -> FSM returns to IDLE; no byte is accepted and no flags are set.
REQ-034 Write 17 words -> addresses 0..15 are written; the 17th word sets overflow with no wr_en; word_count=16.
REQ-035 Drop load_en after 2 bytes, raise it again, send 4 bytes -> write at addr 0 holding only the new 4 bytes; cpu_hold follows load_en with a 1-cycle delay.
REQ-036 Assert RST mid-DATA -> all outputs 0 the next cycle; a subsequent full word is written correctly at addr 0.
